// File: rtl/mem_uart_dump_pkg.sv
// mem_uart_dump_pkg: FSM states, UART frame constants and baud divider helper for the memory dump unit.
package mem_uart_dump_pkg;
  typedef enum logic [3:0] {
    IDLE,
    RD,
    LAT,
    TX_LO,
    TX_HI,
    NXT,
`ifdef MEM_DUMP_CHECKSUM_EN
    CKSUM,
    CKW,
`endif
    FIN
  } state_t;
  localparam logic UART_START = 1'b0;
  localparam logic UART_STOP = 1'b1;
  localparam int UART_DATA_BITS = 8;
  function automatic int bit_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/mem_uart_dump_if.sv
// mem_uart_dump_if: start/BRAM-read/UART bundle; slave is the dump unit, master the host plus BRAM side.
interface mem_uart_dump_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic i_start;
  logic [ADDR_W-1:0] i_last_addr;
  logic o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic o_tx;
  logic o_busy;
  logic o_done;
  modport master (
    output i_start, i_last_addr, i_rd_data,
    input o_rd_en, o_rd_addr, o_tx, o_busy, o_done
  );
  modport slave (
    input i_start, i_last_addr, i_rd_data,
    output o_rd_en, o_rd_addr, o_tx, o_busy, o_done
  );
endinterface

// File: rtl/mem_uart_dump_uart_tx.sv
// uart_tx_byte: 8N1 byte transmitter; o_ready is high when idle and in the final stop-bit cycle.
module uart_tx_byte
  import mem_uart_dump_pkg::*;
#(
  parameter int BIT_DIV = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx
);
  localparam int CNT_W = $clog2(BIT_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_DIV - 1);
  logic [CNT_W-1:0] cnt;
  logic [3:0] idx;
  logic [8:0] sh;
  logic busy;
  logic last_cycle;
  always_comb begin
    last_cycle = idx == 4'(UART_DATA_BITS + 1) && cnt == CNT_MAX;
    o_ready = !busy || last_cycle;
  end
  // sh holds the remaining data bits followed by the stop bit, shifted out LSB first
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      busy <= 1'b0;
      cnt <= '0;
      idx <= '0;
      sh <= '1;
      o_tx <= UART_STOP;
    end else if (i_valid && o_ready) begin
      busy <= 1'b1;
      cnt <= '0;
      idx <= '0;
      sh <= {UART_STOP, i_data};
      o_tx <= UART_START;
    end else if (busy) begin
      cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (cnt == CNT_MAX) begin
        busy <= !last_cycle;
        idx <= idx + 1'b1;
        o_tx <= last_cycle ? UART_STOP : sh[0];
        sh <= {UART_STOP, sh[8:1]};
      end
    end
  end
endmodule

// File: rtl/mem_uart_dump.sv
// mem_uart_dump: reads BRAM words 0..last and sends each low byte then high byte over UART 8N1.
// Define MEM_DUMP_CHECKSUM_EN to append one XOR-of-all-data-bytes checksum byte.
module mem_uart_dump
  import mem_uart_dump_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 115_200,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic i_clk,
  input logic i_rst,
  mem_uart_dump_if.slave bus
);
  state_t state;
  logic [ADDR_W-1:0] last;
  logic [DATA_W-1:8] hi;
  logic tx_valid;
  logic tx_ready;
  logic [7:0] tx_data;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] cksum;
`endif
  // low byte goes straight from the BRAM output in LAT so the start bit lands 3 cycles after start
  always_comb begin
    tx_valid = state == LAT || state == TX_LO;
    tx_data = state == LAT ? bus.i_rd_data[7:0] : hi;
`ifdef MEM_DUMP_CHECKSUM_EN
    if (state == CKSUM) begin
      tx_valid = 1'b1;
      tx_data = cksum;
    end
`endif
  end
  uart_tx_byte #(
    .BIT_DIV(bit_div(CLK_FREQ, BAUD))
  ) u_tx (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(tx_valid),
    .i_data(tx_data),
    .o_ready(tx_ready),
    .o_tx(bus.o_tx)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last <= '0;
      hi <= '0;
      bus.o_rd_en <= 1'b0;
      bus.o_rd_addr <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum <= '0;
`endif
    end else begin
      bus.o_rd_en <= 1'b0;
      bus.o_done <= 1'b0;
      case (state)
        IDLE: if (bus.i_start) begin
          state <= RD;
          last <= bus.i_last_addr;
          bus.o_rd_addr <= '0;
          bus.o_rd_en <= 1'b1;
          bus.o_busy <= 1'b1;
        end
        RD: state <= LAT;
        LAT: begin
          hi <= bus.i_rd_data[DATA_W-1:8];
          state <= TX_LO;
        end
        TX_LO: if (tx_ready) state <= TX_HI;
        TX_HI: if (tx_ready) state <= NXT;
        NXT: if (bus.o_rd_addr == last) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          state <= CKSUM;
`else
          state <= FIN;
          bus.o_done <= 1'b1;
`endif
        end else begin
          bus.o_rd_addr <= bus.o_rd_addr + 1'b1;
          bus.o_rd_en <= 1'b1;
          state <= RD;
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        CKSUM: if (tx_ready) state <= CKW;
        CKW: if (tx_ready) begin
          state <= FIN;
          bus.o_done <= 1'b1;
        end
`endif
        FIN: begin
          state <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_DUMP_CHECKSUM_EN
      if (state == IDLE) cksum <= '0;
      else if (tx_valid && tx_ready && state != CKSUM) cksum <= cksum ^ tx_data;
`endif
    end
  end
endmodule

// File: tb/tb_mem_uart_dump.sv
// tb_mem_uart_dump: scoreboard bench; a fast-baud instance for content tests, a default instance for bit timing.
module tb_mem_uart_dump;
  localparam int F_DIV = 4;
  localparam int S_DIV = 868;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_uart_dump_if #(.ADDR_W(8), .DATA_W(16)) fb ();
  mem_uart_dump_if #(.ADDR_W(8), .DATA_W(16)) sb ();

  mem_uart_dump #(.CLK_FREQ(100_000_000), .BAUD(25_000_000), .ADDR_W(8), .DATA_W(16)) u_fast (
    .i_clk(clk), .i_rst(rst), .bus(fb.slave)
  );
  mem_uart_dump #(.CLK_FREQ(100_000_000), .BAUD(115_200), .ADDR_W(8), .DATA_W(16)) u_slow (
    .i_clk(clk), .i_rst(rst), .bus(sb.slave)
  );

  logic [15:0] fmem [256];
  logic [15:0] smem [256];
  always @(posedge clk) begin
    if (fb.o_rd_en) fb.i_rd_data <= fmem[fb.o_rd_addr];
    if (sb.o_rd_en) sb.i_rd_data <= smem[sb.o_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int rst_epoch = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int wraps = 0;
  bit prev_ff = 1'b0;

  always @(posedge clk) begin
    if (fb.o_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (prev_ff && fb.o_rd_addr == 8'h00) wraps <= wraps + 1;
      prev_ff <= fb.o_rd_addr == 8'hFF;
    end else if (fb.o_done) prev_ff <= 1'b0;
    if (fb.o_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART monitor: decodes fast-instance frames at mid-bit and compares against the scoreboard
  initial begin
    logic [9:0] bits;
    int ep;
    bits = '0;
    forever begin
      @(posedge clk); #1;
      if (fb.o_tx === 1'b0) begin
        ep = rst_epoch;
        for (int k = 1; k < 10 * F_DIV - 1 && ep == rst_epoch; k++) begin
          @(posedge clk); #1;
          if (k % F_DIV == F_DIV / 2) bits[k / F_DIV] = fb.o_tx;
        end
        if (ep == rst_epoch) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL uart_byte: got %02h with nothing expected", bits[8:1]);
          end else begin
            check("uart_byte", 32'(bits[8:1]), 32'(exp_q.pop_front()));
            check("uart_framing", {bits[9], bits[0]}, 2'b10);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] last);
    logic [7:0] x = '0;
    for (int a = 0; a <= int'(last); a++) begin
      exp_q.push_back(fmem[a][7:0]);
      exp_q.push_back(fmem[a][15:8]);
      x ^= fmem[a][7:0] ^ fmem[a][15:8];
    end
`ifdef MEM_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic wait_done(input bit noise, input int limit);
    int c = 0;
    bit got = 1'b0;
    while (!got && c < limit) begin
      @(negedge clk);
      c++;
      got = fb.o_done;
      fb.i_start = noise && !got && c % 100 == 0;
      if (fb.i_start) fb.i_last_addr = 8'(c / 100 * 37);
    end
    fb.i_start = 1'b0;
    check("done_seen", 32'(got), 1);
  endtask

  task automatic run_dump(input logic [7:0] last, input bit noise);
    int r0 = rd_cnt;
    int d0 = done_cnt;
    push_exp(last);
    fb.i_last_addr = last;
    fb.i_start = 1'b1;
    @(negedge clk);
    fb.i_start = 1'b0;
    wait_done(noise, (int'(last) + 1) * (20 * F_DIV + 3) + 200);
    repeat (3) @(negedge clk);
    check("rd_en_count", rd_cnt - r0, int'(last) + 1);
    check("done_count", done_cnt - d0, 1);
    check("busy_after", 32'(fb.o_busy), 0);
    check("bytes_left", exp_q.size(), 0);
  endtask

  initial begin
    logic [19:0] sbits;
    int bad;
    fb.i_start = 1'b0;
    fb.i_last_addr = '0;
    sb.i_start = 1'b0;
    sb.i_last_addr = '0;
    for (int i = 0; i < 256; i++) begin
      fmem[i] = '0;
      smem[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(fb.o_tx), 1);
    check("rst_busy", 32'(fb.o_busy), 0);
    check("rst_done", 32'(fb.o_done), 0);
    check("rst_rd_en", 32'(fb.o_rd_en), 0);
    check("rst_rd_addr", 32'(fb.o_rd_addr), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single word, then a start in the done cycle (ignored) held into the next cycle (accepted)
    fmem[0] = 16'h1234;
    run_dump(8'h00, 1'b0);
    push_exp(8'h00);
    push_exp(8'h00);
    fb.i_last_addr = 8'h00;
    fb.i_start = 1'b1;
    @(negedge clk);
    fb.i_start = 1'b0;
    wait_done(1'b0, 400);
    check("busy_in_done", 32'(fb.o_busy), 1);
    fb.i_start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 32'(fb.o_busy), 0);
    @(negedge clk);
    check("start_after_done", 32'(fb.o_busy), 1);
    fb.i_start = 1'b0;
    wait_done(1'b0, 400);
    repeat (3) @(negedge clk);
    check("bytes_left", exp_q.size(), 0);

    // four words, clean and with start noise while busy
    fmem[0] = 16'hA0A1;
    fmem[1] = 16'hB0B1;
    fmem[2] = 16'hC0C1;
    fmem[3] = 16'hD0D1;
    run_dump(8'h03, 1'b0);
    run_dump(8'h03, 1'b1);

    // reset (with a simultaneous start) in a data bit of byte 3, then a clean redump
    push_exp(8'h03);
    fb.i_last_addr = 8'h03;
    fb.i_start = 1'b1;
    @(negedge clk);
    fb.i_start = 1'b0;
    for (int c = 0; c < 1000 && exp_q.size() > 5; c++) @(negedge clk);
    check("bytes_before_rst", exp_q.size(), 5);
    repeat (15) @(negedge clk);
    check("tx_before_rst", 32'(fb.o_tx), 0);
    rst = 1'b1;
    fb.i_start = 1'b1;
    rst_epoch++;
    exp_q.delete();
    @(negedge clk);
    check("rst_abort_tx", 32'(fb.o_tx), 1);
    check("rst_abort_busy", 32'(fb.o_busy), 0);
    check("rst_abort_rd_en", 32'(fb.o_rd_en), 0);
    fb.i_start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_beats_start", 32'(fb.o_busy), 0);
    repeat (5) @(negedge clk);
    run_dump(8'h03, 1'b0);

    // full address space, must stop at 0xFF without wrapping
    for (int i = 0; i < 256; i++) fmem[i] = {8'(i), ~8'(i)};
    run_dump(8'hFF, 1'b0);
    check("no_wrap", wraps, 0);
    check("final_addr", 32'(fb.o_rd_addr), 32'hFF);

    // default-baud instance: start latency and exact per-bit timing of 0x34, 0x12
    smem[0] = 16'h1234;
    sbits = {1'b1, 8'h12, 1'b0, 1'b1, 8'h34, 1'b0};
    sb.i_last_addr = 8'h00;
    sb.i_start = 1'b1;
    @(negedge clk);
    sb.i_start = 1'b0;
    check("slow_rd_en", 32'(sb.o_rd_en), 1);
    @(negedge clk);
    check("slow_pre_start", 32'(sb.o_tx), 1);
    @(negedge clk);
    check("start_latency", 32'(sb.o_tx), 0);
    for (int b = 0; b < 20; b++) begin
      bad = 0;
      for (int c = 0; c < S_DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (sb.o_tx !== sbits[b]) bad++;
      end
      check($sformatf("bit%0d_timing", b), bad, 0);
    end
    @(negedge clk);
    check("gap_after_word", 32'(sb.o_tx), 1);
    for (int c = 0; c < 30000 && sb.o_done !== 1'b1; c++) @(negedge clk);
    check("slow_done", 32'(sb.o_done), 1);
    @(negedge clk);
    check("slow_busy_after", 32'(sb.o_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
